// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit between execute and data memory.
// Issues byte-masked doubleword accesses and aligns/extends load results.
module lsu_ctrl #(
  parameter int CPU_WIDTH      = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic                      ex_is_load,
  input  logic                      ex_is_store,
  input  logic [2:0]                ex_funct3,
  input  logic [CPU_WIDTH-1:0]      ex_addr,
  input  logic [CPU_WIDTH-1:0]      ex_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_we,
  output logic [CPU_WIDTH-1:0]      mem_req_addr,
  output logic [CPU_WIDTH-1:0]      mem_req_wdata,
  output logic [7:0]                mem_req_wmask,
  input  logic                      mem_rsp_valid,
  input  logic [CPU_WIDTH-1:0]      mem_rsp_rdata,
  output logic                      wb_wen,
  output logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  output logic [CPU_WIDTH-1:0]      wb_wdata,
  output logic                      access_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    WB
  } state_e;

  state_e state_q, state_d;

  logic [2:0]           off;
  logic                 is_op;
  logic                 mis;
  logic                 bad_f3;
  logic                 err;
  logic [7:0]           st_mask;
  logic [CPU_WIDTH-1:0] st_data;
  logic                 accept;
  logic                 start;

  logic                      ld_q;
  logic [2:0]                f3_q;
  logic [2:0]                off_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [CPU_WIDTH-1:0]      ld_sh;
  logic [CPU_WIDTH-1:0]      ld_ext;

  assign ex_ready = (state_q == IDLE);
  assign accept   = ex_valid & ex_ready;
  assign start    = accept & is_op & ~err;

  // Request decode: offset, alignment/funct3 errors, mask, shifted data
  always_comb begin
    off   = ex_addr[2:0];
    is_op = ex_is_load | ex_is_store;
    unique case (ex_funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      default: mis = |off;
    endcase
    if (ex_is_store) bad_f3 = ex_funct3[2];
    else             bad_f3 = &ex_funct3;
    err = (ex_is_load & ex_is_store)
        | (is_op & (bad_f3 | mis));
    unique case (ex_funct3[1:0])
      2'b00:   st_mask = 8'h01 << off;
      2'b01:   st_mask = 8'h03 << off;
      2'b10:   st_mask = 8'h0F << off;
      default: st_mask = 8'hFF;
    endcase
    st_data = ex_store_data << {off, 3'b000};
  end

  // Load alignment and sign/zero extension of the returned doubleword
  always_comb begin
    ld_sh = mem_rsp_rdata >> {off_q, 3'b000};
    unique case (f3_q)
      3'b000:  ld_ext = {{(CPU_WIDTH-8){ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_ext = {{(CPU_WIDTH-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b010:  ld_ext = {{(CPU_WIDTH-32){ld_sh[31]}}, ld_sh[31:0]};
      3'b100:  ld_ext = {{(CPU_WIDTH-8){1'b0}}, ld_sh[7:0]};
      3'b101:  ld_ext = {{(CPU_WIDTH-16){1'b0}}, ld_sh[15:0]};
      3'b110:  ld_ext = {{(CPU_WIDTH-32){1'b0}}, ld_sh[31:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ: begin
        if (mem_req_ready) begin
          if (ld_q) state_d = WAIT;
          else      state_d = IDLE;
        end
      end
      WAIT: if (mem_rsp_valid) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the accepted request's load context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q  <= 1'b0;
      f3_q  <= 3'b000;
      off_q <= 3'b000;
      rd_q  <= '0;
    end else if (start) begin
      ld_q  <= ex_is_load;
      f3_q  <= ex_funct3;
      off_q <= off;
      rd_q  <= ex_rd;
    end
  end

  // Registered outputs toward memory, write-back and error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      access_err    <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= 8'h00;
      wb_wen        <= 1'b0;
      wb_waddr      <= '0;
      wb_wdata      <= '0;
    end else begin
      access_err    <= accept & err;
      mem_req_valid <= (state_d == REQ);
      wb_wen        <= (state_d == WB) & (rd_q != '0);
      if (start) begin
        mem_req_we    <= ex_is_store;
        mem_req_addr  <= {ex_addr[CPU_WIDTH-1:3], 3'b000};
        mem_req_wmask <= ex_is_store ? st_mask : 8'h00;
        mem_req_wdata <= ex_is_store ? st_data : '0;
      end
      if ((state_q == WAIT) && mem_rsp_valid) begin
        wb_wdata <= ld_ext;
        wb_waddr <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl
// against a byte-level reference model.
module tb_lsu_ctrl;

  logic        clk = 0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_store_data;
  logic [4:0]  ex_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic        access_err;

  int n_chk = 0;
  int n_err = 0;

  int          o_err, o_hs, o_reqcyc, o_stall, o_wens, o_wen_cyc;
  bit          o_unstable, o_we;
  logic [4:0]  o_waddr;
  logic [63:0] o_wdata, o_addr, o_wd;
  logic [7:0]  o_mask;

  lsu_ctrl #(.CPU_WIDTH(64), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .access_err(access_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: byte enables covering [off, off+size)
  function automatic logic [7:0] m_mask(int off, int size);
    logic [7:0] m = 8'h00;
    for (int b = 0; b < 8; b++)
      if (b >= off && b < off + size) m[b] = 1'b1;
    return m;
  endfunction

  // Reference: store operand byte i lands in memory byte off+i
  function automatic logic [63:0] m_wdata(logic [63:0] d, int off);
    logic [63:0] w = '0;
    for (int b = 0; b < 8; b++)
      if (b >= off) w[8*b +: 8] = d[8*(b-off) +: 8];
    return w;
  endfunction

  // Reference: gather size bytes from off, then extend
  function automatic logic [63:0] m_load(logic [63:0] r, int off, int size, bit sgn);
    logic [63:0] v = '0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = r[8*(off+i) +: 8];
    if (sgn && size < 8 && v[8*size-1])
      for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Drive one request, play memory, record what the DUT did
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] data,
                        input logic [4:0] rd, input logic [63:0] rdata,
                        input int rdy_dly, input int rsp_dly, input bit noise);
    int rsp_wait;
    o_err = 0; o_hs = 0; o_reqcyc = 0; o_stall = 0; o_wens = 0;
    o_wen_cyc = -1; o_unstable = 0; o_we = 0; o_waddr = '0;
    o_wdata = '0; o_addr = '0; o_wd = '0; o_mask = '0;
    rsp_wait = -1;
    ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_store_data = data; ex_rd = rd;
    @(posedge clk); #1;
    ex_valid = 0; ex_is_load = $urandom_range(0, 1);
    ex_is_store = $urandom_range(0, 1); ex_funct3 = 3'($urandom);
    ex_addr = rnd64(); ex_store_data = rnd64(); ex_rd = 5'($urandom);
    for (int c = 0; c < rdy_dly + rsp_dly + 6; c++) begin
      if (access_err) o_err++;
      if (!ex_ready) o_stall++;
      if (wb_wen) begin
        o_wens++; o_wen_cyc = c; o_waddr = wb_waddr; o_wdata = wb_wdata;
      end
      mem_rsp_valid = 0;
      mem_rsp_rdata = rnd64();
      if (rsp_wait == 0) begin
        mem_rsp_valid = 1; mem_rsp_rdata = rdata;
      end else if (rsp_wait < 0 && noise) begin
        mem_rsp_valid = 1'($urandom_range(0, 1));
      end
      if (rsp_wait >= 0) rsp_wait--;
      mem_req_ready = 0;
      if (mem_req_valid) begin
        if (o_reqcyc == 0) begin
          o_we = mem_req_we; o_addr = mem_req_addr;
          o_mask = mem_req_wmask; o_wd = mem_req_wdata;
        end else if ({mem_req_we, mem_req_addr, mem_req_wmask, mem_req_wdata}
                     != {o_we, o_addr, o_mask, o_wd}) begin
          o_unstable = 1;
        end
        if (o_reqcyc >= rdy_dly) begin
          mem_req_ready = 1; o_hs++;
          if (!mem_req_we) rsp_wait = rsp_dly;
        end
        o_reqcyc++;
      end else if (noise) begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    mem_req_ready = 0; mem_rsp_valid = 0;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
         wb_wen, wb_waddr, wb_wdata, access_err} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got nonzero, required all zero");
    end
    n_chk++;
    if (ex_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready);
    end
  endtask

  task automatic test_store_sb();
    run_op(0, 1, 3'b000, 64'h8000_0005, 64'h1122_3344_5566_77AB, 5'd0, '0, 0, 0, 0);
    n_chk++;
    if (o_hs !== 1 || o_we !== 1'b1) begin
      n_err++; $display("FAIL sb_req: got hs=%0d we=%b want hs=1 we=1", o_hs, o_we);
    end
    n_chk++;
    if (o_addr !== 64'h8000_0000) begin
      n_err++; $display("FAIL sb_addr: got %h want 80000000", o_addr);
    end
    n_chk++;
    if (o_mask !== 8'h20) begin
      n_err++; $display("FAIL sb_mask: got %h want 20", o_mask);
    end
    n_chk++;
    if (o_wd[47:40] !== 8'hAB) begin
      n_err++; $display("FAIL sb_wdata: got %h want AB", o_wd[47:40]);
    end
    n_chk++;
    if (o_stall !== 1) begin
      n_err++; $display("FAIL sb_stall: got %0d want 1", o_stall);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b010, 3'b110};
    logic [63:0] ad  [4] = '{64'h8000_0003, 64'h8000_0003, 64'h8000_0004, 64'h8000_0004};
    logic [63:0] rd  [4] = '{64'h8000_0000, 64'h8000_0000,
                             64'h8765_4321_0000_0000, 64'h8765_4321_0000_0000};
    logic [63:0] exp [4] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80,
                             64'hFFFF_FFFF_8765_4321, 64'h0000_0000_8765_4321};
    for (int i = 0; i < 4; i++) begin
      run_op(1, 0, f3[i], ad[i], rnd64(), 5'd5, rd[i], 0, 0, 0);
      n_chk++;
      if (o_wens !== 1 || o_waddr !== 5'd5 || o_wen_cyc !== 2) begin
        n_err++;
        $display("FAIL ld%0d_wb: got wens=%0d waddr=%0d cyc=%0d want 1/5/2",
                 i, o_wens, o_waddr, o_wen_cyc);
      end
      n_chk++;
      if (o_wdata !== exp[i]) begin
        n_err++; $display("FAIL ld%0d_data: got %h want %h", i, o_wdata, exp[i]);
      end
      n_chk++;
      if (o_stall !== 3 || o_mask !== 8'h00 || o_we !== 1'b0) begin
        n_err++;
        $display("FAIL ld%0d_req: got stall=%0d mask=%h we=%b want 3/00/0",
                 i, o_stall, o_mask, o_we);
      end
    end
  endtask

  task automatic test_errors();
    bit          ld [3] = '{0, 1, 1};
    bit          st [3] = '{1, 0, 1};
    logic [2:0]  f3 [3] = '{3'b001, 3'b111, 3'b000};
    logic [63:0] ad [3] = '{64'h8000_0001, 64'h8000_0000, 64'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      run_op(ld[i], st[i], f3[i], ad[i], rnd64(), 5'd7, rnd64(), 0, 0, 0);
      n_chk++;
      if (o_err !== 1 || o_reqcyc !== 0 || o_stall !== 0 || o_wens !== 0) begin
        n_err++;
        $display("FAIL err%0d: got err=%0d req=%0d stall=%0d wen=%0d want 1/0/0/0",
                 i, o_err, o_reqcyc, o_stall, o_wens);
      end
    end
  endtask

  task automatic test_backpressure();
    run_op(0, 1, 3'b011, 64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 5'd0, '0, 3, 0, 0);
    n_chk++;
    if (o_hs !== 1 || o_reqcyc !== 4 || o_unstable !== 0) begin
      n_err++;
      $display("FAIL sd_hold: got hs=%0d vcyc=%0d unstable=%b want 1/4/0",
               o_hs, o_reqcyc, o_unstable);
    end
    n_chk++;
    if (o_mask !== 8'hFF || o_wd !== 64'hDEAD_BEEF_CAFE_F00D || o_addr !== 64'h8000_0010) begin
      n_err++;
      $display("FAIL sd_fields: got mask=%h wd=%h addr=%h", o_mask, o_wd, o_addr);
    end
    n_chk++;
    if (o_stall !== 4) begin
      n_err++; $display("FAIL sd_stall: got %0d want 4", o_stall);
    end
  endtask

  task automatic test_rd0();
    run_op(1, 0, 3'b011, 64'h8000_0008, '0, 5'd0, 64'h1234_5678_9ABC_DEF0, 0, 1, 0);
    n_chk++;
    if (o_hs !== 1 || o_we !== 1'b0 || o_wens !== 0 || o_stall !== 4) begin
      n_err++;
      $display("FAIL ld_rd0: got hs=%0d we=%b wens=%0d stall=%0d want 1/0/0/4",
               o_hs, o_we, o_wens, o_stall);
    end
  endtask

  task automatic test_reset_wait();
    int wens;
    ex_valid = 1; ex_is_load = 1; ex_is_store = 0; ex_funct3 = 3'b011;
    ex_addr = 64'h8000_0020; ex_rd = 5'd9;
    @(posedge clk); #1;
    ex_valid = 0; mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
         wb_wen, wb_waddr, wb_wdata, access_err} !== '0 || ex_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_wait: outputs not cleared, ex_ready=%b", ex_ready);
    end
    @(posedge clk); #1;
    rst_n = 1; mem_rsp_valid = 1; mem_rsp_rdata = 64'hFFFF_0000_FFFF_0000;
    wens = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      mem_rsp_valid = 0;
      if (wb_wen || mem_req_valid || !ex_ready) wens++;
    end
    n_chk++;
    if (wens !== 0) begin
      n_err++; $display("FAIL rst_wait_rsp: got %0d active cycles want 0", wens);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      int k, off, size, rdy, rsp;
      bit ld, st, e;
      logic [2:0] f3;
      logic [63:0] a, d, r;
      logic [4:0] rd;
      k = $urandom_range(0, 9);
      ld = (k == 0) || (k >= 6);
      st = (k == 0) || (k >= 2 && k <= 5);
      f3 = 3'($urandom);
      a = {32'h8000_0000, 29'($urandom), 3'($urandom)};
      d = rnd64(); r = rnd64(); rd = 5'($urandom_range(0, 31));
      rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
      off = int'(a[2:0]); size = 1 << f3[1:0];
      e = (ld && st) || ((ld || st) &&
          ((st && f3[2]) || (ld && f3 == 3'b111) || (off % size != 0)));
      run_op(ld, st, f3, a, d, rd, r, rdy, rsp, 1);
      n_chk++;
      if (o_err !== int'(e)) begin
        n_err++; $display("FAIL rnd%0d_err: got %0d want %0d", i, o_err, e);
      end
      if (e || !(ld || st)) begin
        n_chk++;
        if (o_reqcyc !== 0 || o_stall !== 0 || o_wens !== 0) begin
          n_err++;
          $display("FAIL rnd%0d_noop: got req=%0d stall=%0d wen=%0d want 0",
                   i, o_reqcyc, o_stall, o_wens);
        end
      end else if (st) begin
        n_chk++;
        if (o_hs !== 1 || o_reqcyc !== rdy + 1 || o_unstable || o_we !== 1'b1 ||
            o_addr !== {a[63:3], 3'b000} || o_mask !== m_mask(off, size) ||
            o_wd !== m_wdata(d, off) || o_stall !== rdy + 1 || o_wens !== 0) begin
          n_err++;
          $display("FAIL rnd%0d_st: got hs=%0d mask=%h wd=%h stall=%0d want mask=%h wd=%h stall=%0d",
                   i, o_hs, o_mask, o_wd, o_stall, m_mask(off, size), m_wdata(d, off), rdy + 1);
        end
      end else begin
        n_chk++;
        if (o_hs !== 1 || o_reqcyc !== rdy + 1 || o_we !== 1'b0 || o_mask !== 8'h00 ||
            o_addr !== {a[63:3], 3'b000} || o_stall !== rdy + rsp + 3 ||
            o_wens !== int'(rd != 0)) begin
          n_err++;
          $display("FAIL rnd%0d_ld: got hs=%0d stall=%0d wens=%0d want stall=%0d wens=%0d",
                   i, o_hs, o_stall, o_wens, rdy + rsp + 3, rd != 0);
        end
        if (rd != 0) begin
          n_chk++;
          if (o_waddr !== rd || o_wen_cyc !== rdy + rsp + 2 ||
              o_wdata !== m_load(r, off, size, !f3[2])) begin
            n_err++;
            $display("FAIL rnd%0d_wb: got rd=%0d cyc=%0d data=%h want %0d/%0d/%h",
                     i, o_waddr, o_wen_cyc, o_wdata, rd, rdy + rsp + 2,
                     m_load(r, off, size, !f3[2]));
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 0; ex_valid = 0; ex_is_load = 0; ex_is_store = 0;
    ex_funct3 = '0; ex_addr = '0; ex_store_data = '0; ex_rd = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1;
    @(posedge clk); #1;
    test_store_sb();
    test_load_ext();
    test_errors();
    test_backpressure();
    test_rd0();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
